// File: rtl/tsu_queue_merge.sv
// Merges NUM_CH tsu timestamp read queues into one channel-tagged FIFO for the host.
// Three-state read sequence per entry (grant, pop, capture); single clock domain.

module tsu_queue_merge_lane #(
  parameter int STAT_W = 8,
  parameter int DATA_W = 56
) (
  input  logic [STAT_W-1:0] stat,
  input  logic [DATA_W-1:0] data,
  input  logic              sel,
  output logic              elig,
  output logic [DATA_W-1:0] word
);
  assign elig = |stat;
  // Gated word feeds an AND-OR capture mux in the parent.
  assign word = sel ? data : '0;
endmodule

module tsu_queue_merge #(
  parameter int NUM_CH     = 2,
  parameter int CH_W       = 1,
  parameter int DATA_W     = 56,
  parameter int STAT_W     = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int PRIORITY   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [NUM_CH-1:0]        ch_rd_en,
  input  logic [NUM_CH*STAT_W-1:0] ch_rd_stat,
  input  logic [NUM_CH*DATA_W-1:0] ch_rd_data,
  input  logic                     out_rd_en,
  output logic [STAT_W-1:0]        out_rd_stat,
  output logic [CH_W+DATA_W-1:0]   out_rd_data,
  output logic                     out_underflow
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int ENT_W = CH_W + DATA_W;

  typedef enum logic [1:0] {S_ARB, S_WAIT, S_CAPT} state_t;

  state_t                         state_q, state_d;
  logic [CH_W-1:0]                gnt_q, gnt_d, rr_q, rr_d, win;
  logic                           win_vld, wr_fire, rd_fire, full;
  logic [NUM_CH-1:0]              elig, en_d, lane_sel;
  logic [NUM_CH-1:0][DATA_W-1:0]  lane_word;
  logic [DATA_W-1:0]              cap_word;
  logic [ENT_W-1:0]               mem [DEPTH];
  logic [DEPTH_LOG2-1:0]          wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]            fill;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    assign lane_sel[i] = (gnt_q == CH_W'(i));
    tsu_queue_merge_lane #(.STAT_W(STAT_W), .DATA_W(DATA_W)) u_lane (
      .stat (ch_rd_stat[i*STAT_W +: STAT_W]),
      .data (ch_rd_data[i*DATA_W +: DATA_W]),
      .sel  (lane_sel[i]),
      .elig (elig[i]),
      .word (lane_word[i])
    );
  end

  always_comb begin
    cap_word = '0;
    for (int i = 0; i < NUM_CH; i++) cap_word = cap_word | lane_word[i];
  end

  // Candidates are scanned from farthest to nearest so the last hit is the winner.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (PRIORITY != 0) begin
        if (elig[k-1]) begin
          win_vld = 1'b1;
          win     = CH_W'(k-1);
        end
      end else if (elig[(int'(rr_q) + k) % NUM_CH]) begin
        win_vld = 1'b1;
        win     = CH_W'((int'(rr_q) + k) % NUM_CH);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_ARB;
      gnt_q    <= '0;
      rr_q     <= CH_W'(NUM_CH - 1);
      ch_rd_en <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_q     <= rr_d;
      ch_rd_en <= en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    en_d    = '0;
    wr_fire = 1'b0;
    case (state_q)
      S_ARB: begin
        // Only one entry is ever in flight, so a free slot now is a free slot at capture.
        if (win_vld && !full) begin
          gnt_d   = win;
          en_d    = NUM_CH'(1) << win;
          state_d = S_WAIT;
        end
      end
      S_WAIT: state_d = S_CAPT;
      S_CAPT: begin
        wr_fire = 1'b1;
        rr_d    = gnt_q;
        state_d = S_ARB;
      end
      default: state_d = S_ARB;
    endcase
  end

  assign full        = fill[DEPTH_LOG2];
  assign rd_fire     = out_rd_en && (fill != '0);
  assign out_rd_stat = STAT_W'(fill);

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= {gnt_q, cap_word};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fill          <= '0;
      out_rd_data   <= '0;
      out_underflow <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) begin
        rd_ptr      <= rd_ptr + 1'b1;
        out_rd_data <= mem[rd_ptr];
      end
      if (out_rd_en && fill == '0) out_underflow <= 1'b1;
      case ({wr_fire, rd_fire})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_tsu_queue_merge.sv
// Bench for tsu_queue_merge: round-robin and fixed-priority instances share stimulus;
// a queue/arbitration-rule reference model predicts grants, occupancy and host data.

module tb_tsu_queue_merge;
  localparam int NC  = 3;
  localparam int CW  = 2;
  localparam int DW  = 56;
  localparam int SW  = 8;
  localparam int DL  = 2;
  localparam int DEP = 4;
  localparam int NI  = 2;   // instance 0: round-robin, instance 1: fixed priority

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic out_rd_en = 1'b0;
  always #5 clk = ~clk;

  logic [NC-1:0]    ch_rd_en      [NI];
  logic [NC*SW-1:0] ch_rd_stat    [NI];
  logic [NC*DW-1:0] ch_rd_data    [NI];
  logic [SW-1:0]    out_rd_stat   [NI];
  logic [CW+DW-1:0] out_rd_data   [NI];
  logic             out_underflow [NI];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    tsu_queue_merge #(.NUM_CH(NC), .CH_W(CW), .DATA_W(DW), .STAT_W(SW),
                      .DEPTH_LOG2(DL), .PRIORITY(gi)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .ch_rd_en      (ch_rd_en[gi]),
      .ch_rd_stat    (ch_rd_stat[gi]),
      .ch_rd_data    (ch_rd_data[gi]),
      .out_rd_en     (out_rd_en),
      .out_rd_stat   (out_rd_stat[gi]),
      .out_rd_data   (out_rd_data[gi]),
      .out_underflow (out_underflow[gi])
    );
  end

  // tsu queue models: pushed by the stimulus, popped by ch_rd_en, word valid next cycle
  logic [DW-1:0] qmem [NI][NC][256];
  int wr_i [NI][NC];
  int rd_i [NI][NC];

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++)
      for (int c = 0; c < NC; c++)
        if (rst && ch_rd_en[i][c] && rd_i[i][c] != wr_i[i][c]) begin
          ch_rd_data[i][c*DW +: DW] <= qmem[i][c][rd_i[i][c] % 256];
          rd_i[i][c] <= rd_i[i][c] + 1;
        end
  end

  always_comb begin
    for (int i = 0; i < NI; i++)
      for (int c = 0; c < NC; c++)
        ch_rd_stat[i][c*SW +: SW] = SW'(wr_i[i][c] - rd_i[i][c]);
  end

  // reference model state
  int               ph     [NI];   // 0 arbitrating, 1 read pulse, 2 capture
  int               lastg  [NI];
  int               pg     [NI];
  logic [CW+DW-1:0] pend   [NI];
  bit               commit [NI];
  logic [CW+DW-1:0] eb     [NI][16];
  int               ehd    [NI];
  int               ecnt   [NI];
  logic [CW+DW-1:0] exp_data [NI];
  logic             exp_uf [NI];
  int               gcnt   [NI];
  int               glog   [NI][256];
  int               n_pass = 0;
  int               n_chk  = 0;

  task automatic chk(input string tag, input int inst, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s[%0d] observed=%h expected=%h", tag, inst, obs, expv);
  endtask

  task automatic push(input int c, input logic [DW-1:0] w);
    for (int i = 0; i < NI; i++) begin
      qmem[i][c][wr_i[i][c] % 256] = w;
      wr_i[i][c] = wr_i[i][c] + 1;
    end
  endtask

  // One model step per cycle, evaluated at the falling edge.
  task automatic step();
    for (int i = 0; i < NI; i++) begin
      int w;
      if (!rst) begin
        chk("rst_en",   i, 64'(ch_rd_en[i]), 64'(0));
        chk("rst_stat", i, 64'(out_rd_stat[i]), 64'(0));
        chk("rst_data", i, 64'(out_rd_data[i]), 64'(0));
        chk("rst_uf",   i, 64'(out_underflow[i]), 64'(0));
        ph[i] = 0; lastg[i] = NC - 1; commit[i] = 1'b0;
        ehd[i] = 0; ecnt[i] = 0; exp_data[i] = '0; exp_uf[i] = 1'b0;
        continue;
      end
      if (commit[i]) begin
        eb[i][(ehd[i] + ecnt[i]) % 16] = pend[i];
        ecnt[i]++;
        commit[i] = 1'b0;
      end
      chk("stat", i, 64'(out_rd_stat[i]), 64'(ecnt[i]));
      chk("data", i, 64'(out_rd_data[i]), 64'(exp_data[i]));
      chk("uf",   i, 64'(out_underflow[i]), 64'(exp_uf[i]));
      case (ph[i])
        1: begin
          chk("rd_en_pulse", i, 64'(ch_rd_en[i]), 64'(1) << pg[i]);
          pend[i] = {CW'(pg[i]), qmem[i][pg[i]][rd_i[i][pg[i]] % 256]};
          ph[i] = 2;
        end
        2: begin
          chk("rd_en_capt", i, 64'(ch_rd_en[i]), 64'(0));
          ph[i] = 0;
          commit[i] = 1'b1;
        end
        default: begin
          chk("rd_en_arb", i, 64'(ch_rd_en[i]), 64'(0));
          w = -1;
          for (int k = 1; k <= NC; k++) begin
            int c;
            c = (i == 1) ? (k - 1) : ((lastg[i] + k) % NC);
            if (w < 0 && wr_i[i][c] != rd_i[i][c]) w = c;
          end
          if (w >= 0 && ecnt[i] < DEP) begin
            pg[i] = w; lastg[i] = w;
            if (gcnt[i] < 256) glog[i][gcnt[i]] = w;
            gcnt[i]++;
            ph[i] = 1;
          end
        end
      endcase
      if (out_rd_en) begin
        if (ecnt[i] > 0) begin
          exp_data[i] = eb[i][ehd[i]];
          ehd[i] = (ehd[i] + 1) % 16;
          ecnt[i]--;
        end else exp_uf[i] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_rd();
    out_rd_en = 1'b1;
    tick();
    out_rd_en = 1'b0;
  endtask

  initial begin
    int base [NI];
    int rr_exp [6];
    int fp_exp [6];
    logic [CW+DW-1:0] held [NI];
    int k;
    rr_exp = '{0, 1, 0, 1, 0, 1};
    fp_exp = '{0, 0, 0, 1, 1, 1};
    #1 rst = 1'b0;

    // reset held with a non-empty channel
    push(1, 56'hA1); push(1, 56'hA2); push(1, 56'hA3);
    repeat (3) tick();
    rst = 1'b1;

    // single channel drain
    for (int i = 0; i < NI; i++) base[i] = gcnt[i];
    repeat (12) tick();
    for (int i = 0; i < NI; i++) begin
      chk("single_grants", i, 64'(gcnt[i] - base[i]), 64'(3));
      chk("single_stat",   i, 64'(out_rd_stat[i]), 64'(3));
    end
    for (int r = 0; r < 3; r++) begin
      host_rd();
      for (int i = 0; i < NI; i++)
        chk("single_rd", i, 64'(out_rd_data[i]), {6'd0, 2'd1, 56'hA1 + 56'(r)});
    end

    // two busy channels: round-robin vs fixed priority
    for (int i = 0; i < NI; i++) base[i] = gcnt[i];
    for (int r = 0; r < 3; r++) begin
      push(0, 56'hB0 + 56'(r));
      push(1, 56'hC0 + 56'(r));
    end
    repeat (14) tick();
    for (int r = 0; r < 6; r++) begin
      host_rd();
      chk("rr_tag", 0, 64'(out_rd_data[0][CW+DW-1:DW]), 64'(rr_exp[r]));
      chk("fp_tag", 1, 64'(out_rd_data[1][CW+DW-1:DW]), 64'(fp_exp[r]));
      repeat (3) tick();
    end
    for (int r = 0; r < 6; r++) begin
      chk("rr_order", 0, 64'(glog[0][base[0] + r]), 64'(rr_exp[r]));
      chk("fp_order", 1, 64'(glog[1][base[1] + r]), 64'(fp_exp[r]));
    end

    // full FIFO stalls, one read frees one slot, write+read keeps count
    for (int i = 0; i < NI; i++) base[i] = gcnt[i];
    for (int r = 0; r < 6; r++) push(0, 56'hD0 + 56'(r));
    repeat (20) tick();
    for (int i = 0; i < NI; i++) begin
      chk("full_stat",   i, 64'(out_rd_stat[i]), 64'(4));
      chk("full_grants", i, 64'(gcnt[i] - base[i]), 64'(4));
    end
    host_rd();
    repeat (4) tick();
    for (int i = 0; i < NI; i++) begin
      chk("refill_stat",   i, 64'(out_rd_stat[i]), 64'(4));
      chk("refill_grants", i, 64'(gcnt[i] - base[i]), 64'(5));
    end
    host_rd();
    repeat (2) tick();
    host_rd();   // lands in the capture cycle of the sixth entry
    for (int i = 0; i < NI; i++) chk("wr_rd_stat", i, 64'(out_rd_stat[i]), 64'(3));
    repeat (4) tick();
    for (int i = 0; i < NI; i++) begin
      chk("after_stat",   i, 64'(out_rd_stat[i]), 64'(3));
      chk("after_grants", i, 64'(gcnt[i] - base[i]), 64'(6));
    end
    repeat (3) host_rd();

    // underflow
    tick();
    for (int i = 0; i < NI; i++) begin
      chk("uf_clear", i, 64'(out_underflow[i]), 64'(0));
      held[i] = out_rd_data[i];
    end
    host_rd();
    tick();
    for (int i = 0; i < NI; i++) begin
      chk("uf_set",  i, 64'(out_underflow[i]), 64'(1));
      chk("uf_hold", i, 64'(out_rd_data[i]), 64'(held[i]));
    end

    // reset during the read pulse
    push(2, 56'hE0);
    k = 0;
    while (ch_rd_en[0] == '0 && k < 10) begin
      tick();
      k++;
    end
    chk("grant_seen", 0, 64'(k < 10), 64'(1));
    rst = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) chk("rst_drop", i, 64'(ch_rd_en[i]), 64'(0));
    repeat (2) tick();
    rst = 1'b1;
    repeat (8) tick();
    for (int i = 0; i < NI; i++) chk("regrant_stat", i, 64'(out_rd_stat[i]), 64'(1));
    host_rd();
    for (int i = 0; i < NI; i++) chk("regrant_rd", i, 64'(out_rd_data[i]), {6'd0, 2'd2, 56'hE0});

    // random traffic against the model
    repeat (400) begin
      if ($urandom_range(3) == 0) push($urandom_range(NC - 1), DW'({$urandom(), $urandom()}));
      out_rd_en = ($urandom_range(2) == 0);
      tick();
    end
    repeat (600) begin
      out_rd_en = ~out_rd_en;
      tick();
    end
    out_rd_en = 1'b0;
    tick();
    for (int i = 0; i < NI; i++) begin
      int left;
      left = 0;
      for (int c = 0; c < NC; c++) left += wr_i[i][c] - rd_i[i][c];
      chk("drain_stat", i, 64'(out_rd_stat[i]), 64'(0));
      chk("drain_q",    i, 64'(left), 64'(0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/tsu_queue_merge.md
Name: tsu_queue_merge

Overview:
- Merges the timestamp read queues of NUM_CH tsu instances (e.g. several GMII RX/TX ports) into one tagged output queue for the host.
- Each merged entry carries the source channel index alongside the 56-bit tsu queue word.
- Lives entirely in the q_rd_clk domain. Replaces per-port host polling of tsu q_rd_* interfaces.
- Selectable round-robin or fixed-priority arbitration; bounded internal FIFO with occupancy and underflow reporting.

Parameters:
- NUM_CH, 2, number of tsu queues merged (2..8).
- CH_W, 1, channel tag width; 2**CH_W >= NUM_CH.
- DATA_W, 56, tsu queue word width.
- STAT_W, 8, width of channel and output occupancy counts.
- DEPTH_LOG2, 4, output FIFO depth = 2**DEPTH_LOG2; must be < 2**STAT_W.
- PRIORITY, 0, arbitration mode: 0 = round-robin, 1 = fixed priority with ch0 highest.

Ports:
- clk  in  1  q_rd_clk domain clock.
- rst  in  1  Asynchronous, active-low reset.
- ch_rd_en  out  NUM_CH  One-hot registered read pulse per tsu queue (drives q_rd_en).
- ch_rd_stat  in  NUM_CH*STAT_W  Per-channel entry count (tsu q_rd_stat); channel i at bits [i*STAT_W +: STAT_W].
- ch_rd_data  in  NUM_CH*DATA_W  Per-channel queue word, valid the cycle after its rd_en is sampled.
- out_rd_en  in  1  Host read strobe.
- out_rd_stat  out  STAT_W  Output FIFO occupancy.
- out_rd_data  out  CH_W+DATA_W  Registered {channel, word}, updated the cycle after an accepted out_rd_en.
- out_underflow  out  1  Sticky; set by out_rd_en while empty.

Behaviour:
- Reset: asynchronous, active-low. While rst=0 and on release:
  - ch_rd_en=0, out_rd_stat=0, out_rd_data=0, out_underflow=0.
  - FIFO pointers=0, FSM=ARB, RR pointer=NUM_CH-1 so ch0 wins first.
- FSM ARB:
  - Eligible channel i: ch_rd_stat[i] != 0.
  - Grant requires at least one eligible channel and fill count < 2**DEPTH_LOG2.
  - On grant: latch grant index g, register ch_rd_en[g]=1, go to WAIT. Otherwise stay in ARB with ch_rd_en=0.
- FSM WAIT:
  - ch_rd_en[g] is high for exactly this one cycle; the tsu queue samples it at the end of the cycle.
  - Clear ch_rd_en, go to CAPT.
- FSM CAPT:
  - Write {g[CH_W-1:0], ch_rd_data[g]} into the FIFO; fill count +1.
  - Update RR pointer to g; go to ARB.
  - ch_rd_stat[g] must reflect the decrement by the next ARB cycle.
- Throughput: one entry per 3 cycles. Read latency from first ARB grant to entry visible in out_rd_stat is 3 edges.
- Arbitration:
  - PRIORITY=0: search from RR pointer+1 upward, wrapping modulo NUM_CH; first eligible channel wins.
  - PRIORITY=1: lowest eligible index wins; the RR pointer is ignored.
- Occupancy guarantee: at most one entry is in flight, so the fill-count check in ARB guarantees no FIFO overflow. A full FIFO stalls all channels; tsu queues buffer the backlog.
- Host read:
  - out_rd_en with count > 0: out_rd_data <= head entry next edge; head pointer +1.
  - out_rd_en while empty: ignored, out_rd_data holds, out_underflow <= 1 (sticky until reset).
- Simultaneous CAPT write and host read: count unchanged; pointers both advance.
- Full FIFO: a read frees a slot; grant may occur in the following ARB cycle.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. out_rd_stat is the fill count zero-extended to STAT_W.
- Reset mid-operation (WAIT/CAPT): the in-flight entry is discarded and ch_rd_en drops immediately. A word already popped from a tsu queue is lost; this is accepted behaviour.

Test Plan:
- Reset: rst=0 for 3 cycles with ch_rd_stat nonzero -> ch_rd_en=0, out_rd_stat=0, out_rd_data=0, out_underflow=0 throughout.
- Single channel: ch1 holds words 0xA1, 0xA2, 0xA3 (stat 3->2->1->0) -> exactly three ch_rd_en[1] pulses spaced 3 cycles; out_rd_stat reaches 3; host reads return {1,0xA1}, {1,0xA2}, {1,0xA3} in order.
- Round-robin, PRIORITY=0: ch0 and ch1 each hold 3 entries -> grant order 0,1,0,1,0,1; tags alternate in the output.
- Fixed priority, PRIORITY=1: same stimulus -> grants 0,0,0,1,1,1.
- Full: DEPTH_LOG2=2, ch0 holds 6 entries, no host reads -> out_rd_stat=4 and no further ch_rd_en. One out_rd_en -> exactly one more grant, stat returns to 4. Simultaneous CAPT write plus host read keeps stat constant.
- Underflow/reset: out_rd_en while empty -> out_underflow=1, out_rd_data unchanged. Assert rst=0 during WAIT -> ch_rd_en falls in the same cycle and no entry is written.
